vga_timing_prog: RTL and testbench

Runtime-programmable VGA/raster timing generator. It is the parametrised successor of the fixed-constant sync generator.
- Horizontal/vertical geometry and sync polarity are loaded through a valid/ready config port and applied only at a frame boundary, so no partial frames are produced.
- A configurable delay pipe aligns sync/blank with a downstream pixel-mixer pipeline.
- Adds frame/line start strobes and config error reporting.
- Sits between the pixel PLL/clock-enable and the pixel mixer/DAC.

---
 rtl/vga_timing_pkg.sv | 46 ++++
 rtl/vga_axis_counter.sv | 41 ++++
 rtl/vga_timing_prog.sv | 207 ++++++++++++++++++++
 tb/tb_vga_timing_prog.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared constants and helpers for the programmable raster timing generator.
// Holds the standard 640x480 mode, a tiny test mode and the per-axis derive function.
package vga_timing_pkg;

  localparam int VGA640_H_DISPLAY = 640;
  localparam int VGA640_H_FRONT   = 16;
  localparam int VGA640_H_SYNC    = 96;
  localparam int VGA640_H_BACK    = 48;
  localparam int VGA640_V_DISPLAY = 480;
  localparam int VGA640_V_BOTTOM  = 10;
  localparam int VGA640_V_SYNC    = 2;
  localparam int VGA640_V_TOP     = 33;

  localparam int TEST_H_DISPLAY = 8;
  localparam int TEST_H_FRONT   = 2;
  localparam int TEST_H_SYNC    = 3;
  localparam int TEST_H_BACK    = 1;
  localparam int TEST_V_DISPLAY = 4;
  localparam int TEST_V_BOTTOM  = 1;
  localparam int TEST_V_SYNC    = 2;
  localparam int TEST_V_TOP     = 1;

  typedef enum logic {
    CFG_IDLE    = 1'b0,
    CFG_PENDING = 1'b1
  } cfg_state_t;

  typedef struct packed {
    logic [31:0] sync_start;
    logic [31:0] sync_end;
    logic [31:0] max;
  } axis_derive_t;

  // Wide enough that no sum of four axis fields can overflow.
  function automatic axis_derive_t derive(input logic [31:0] display,
                                          input logic [31:0] porch_a,
                                          input logic [31:0] sync,
                                          input logic [31:0] porch_b);
    axis_derive_t d;
    d.sync_start = display + porch_a;
    d.sync_end   = d.sync_start + sync - 32'd1;
    d.max        = d.sync_end + porch_b;
    return d;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter with wrap detect, plus sync/active
// window compares evaluated on the position the counter is about to take.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         advance,
  input  logic [W+1:0] max,
  input  logic [W+1:0] sync_start,
  input  logic [W+1:0] sync_end,
  input  logic [W-1:0] display,
  output logic [W-1:0] pos,
  output logic         wrap,
  output logic [W-1:0] next_pos,
  output logic         sync_next,
  output logic         active_next
);

  always_comb begin
    wrap     = ({2'b00, pos} == max);
    next_pos = pos;
    if (advance) begin
      next_pos = wrap ? '0 : pos + W'(1);
    end
  end

  assign sync_next   = ({2'b00, next_pos} >= sync_start) && ({2'b00, next_pos} <= sync_end);
  assign active_next = (next_pos < display);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pos <= '0;
    end else if (advance) begin
      pos <= next_pos;
    end
  end

endmodule

// File: rtl/vga_timing_prog.sv
// Runtime-programmable raster timing generator: H/V counters, frame-boundary
// config swap through a valid/ready port, and an output alignment delay pipe.
//
// state       | meaning
// CFG_IDLE    | no config waiting; cfg_ready high, requests are validated
// CFG_PENDING | shadow holds a valid config, swapped in at the next frame wrap
module vga_timing_prog
  import vga_timing_pkg::*;
#(
  parameter int HPOS_WIDTH    = 11,
  parameter int VPOS_WIDTH    = 10,
  parameter int SYNC_DELAY    = 0,
  parameter int DEF_H_DISPLAY = VGA640_H_DISPLAY,
  parameter int DEF_H_FRONT   = VGA640_H_FRONT,
  parameter int DEF_H_SYNC    = VGA640_H_SYNC,
  parameter int DEF_H_BACK    = VGA640_H_BACK,
  parameter int DEF_V_DISPLAY = VGA640_V_DISPLAY,
  parameter int DEF_V_BOTTOM  = VGA640_V_BOTTOM,
  parameter int DEF_V_SYNC    = VGA640_V_SYNC,
  parameter int DEF_V_TOP     = VGA640_V_TOP,
  parameter bit DEF_HSYNC_POL = 1'b0,
  parameter bit DEF_VSYNC_POL = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [HPOS_WIDTH-1:0] cfg_h_display,
  input  logic [HPOS_WIDTH-1:0] cfg_h_front,
  input  logic [HPOS_WIDTH-1:0] cfg_h_sync,
  input  logic [HPOS_WIDTH-1:0] cfg_h_back,
  input  logic [VPOS_WIDTH-1:0] cfg_v_display,
  input  logic [VPOS_WIDTH-1:0] cfg_v_bottom,
  input  logic [VPOS_WIDTH-1:0] cfg_v_sync,
  input  logic [VPOS_WIDTH-1:0] cfg_v_top,
  input  logic                  cfg_hsync_pol,
  input  logic                  cfg_vsync_pol,
  output logic                  cfg_err,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  display_on,
  output logic                  frame_start,
  output logic                  line_start,
  output logic [HPOS_WIDTH-1:0] hpos,
  output logic [VPOS_WIDTH-1:0] vpos
);

  localparam int HW = HPOS_WIDTH;
  localparam int VW = VPOS_WIDTH;

  typedef struct packed {
    logic [HW-1:0] h_display;
    logic [HW-1:0] h_front;
    logic [HW-1:0] h_sync;
    logic [HW-1:0] h_back;
    logic [VW-1:0] v_display;
    logic [VW-1:0] v_bottom;
    logic [VW-1:0] v_sync;
    logic [VW-1:0] v_top;
    logic          hsync_pol;
    logic          vsync_pol;
  } cfg_t;

  localparam cfg_t DEF_CFG = '{
    h_display: HW'(DEF_H_DISPLAY),
    h_front:   HW'(DEF_H_FRONT),
    h_sync:    HW'(DEF_H_SYNC),
    h_back:    HW'(DEF_H_BACK),
    v_display: VW'(DEF_V_DISPLAY),
    v_bottom:  VW'(DEF_V_BOTTOM),
    v_sync:    VW'(DEF_V_SYNC),
    v_top:     VW'(DEF_V_TOP),
    hsync_pol: DEF_HSYNC_POL,
    vsync_pol: DEF_VSYNC_POL
  };

  // Pipe bit order: hsync, vsync, display_on, frame_start, line_start.
  localparam logic [4:0] PIPE_RST = {~DEF_HSYNC_POL, ~DEF_VSYNC_POL, 3'b000};

  cfg_t         act, shadow, eff, cfg_req;
  cfg_state_t   state_q, state_d;
  logic         load_shadow, err_d, apply, req_ok;
  axis_derive_t act_hd, act_vd, eff_hd, eff_vd, req_hd, req_vd;

  logic          h_wrap, v_wrap, h_sync_next, v_sync_next, h_active_next, v_active_next;
  logic [HW-1:0] h_next;
  logic [VW-1:0] v_next;
  logic [4:0]    stage_d;
  logic [4:0]    pipe [0:SYNC_DELAY];

  assign cfg_req = '{
    h_display: cfg_h_display, h_front: cfg_h_front, h_sync: cfg_h_sync, h_back: cfg_h_back,
    v_display: cfg_v_display, v_bottom: cfg_v_bottom, v_sync: cfg_v_sync, v_top: cfg_v_top,
    hsync_pol: cfg_hsync_pol, vsync_pol: cfg_vsync_pol
  };

  // The new config must already shape the (0,0) pixel on the swap cycle.
  assign eff = apply ? shadow : act;

  assign act_hd = derive(32'(act.h_display), 32'(act.h_front), 32'(act.h_sync), 32'(act.h_back));
  assign act_vd = derive(32'(act.v_display), 32'(act.v_bottom), 32'(act.v_sync), 32'(act.v_top));
  assign eff_hd = derive(32'(eff.h_display), 32'(eff.h_front), 32'(eff.h_sync), 32'(eff.h_back));
  assign eff_vd = derive(32'(eff.v_display), 32'(eff.v_bottom), 32'(eff.v_sync), 32'(eff.v_top));
  assign req_hd = derive(32'(cfg_h_display), 32'(cfg_h_front), 32'(cfg_h_sync), 32'(cfg_h_back));
  assign req_vd = derive(32'(cfg_v_display), 32'(cfg_v_bottom), 32'(cfg_v_sync), 32'(cfg_v_top));

  assign req_ok = (cfg_h_display != '0) && (cfg_h_front != '0) && (cfg_h_sync != '0) &&
                  (cfg_h_back != '0) && (cfg_v_display != '0) && (cfg_v_bottom != '0) &&
                  (cfg_v_sync != '0) && (cfg_v_top != '0) &&
                  ((req_hd.max >> HW) == 32'd0) && ((req_vd.max >> VW) == 32'd0);

  // Derive results are wider than any axis needs; only the low bits are consumed.
  logic unused_derive_bits;
  assign unused_derive_bits = ^{act_hd, act_vd, eff_hd, eff_vd, req_hd, req_vd};

  always_comb begin
    state_d     = state_q;
    load_shadow = 1'b0;
    err_d       = 1'b0;
    apply       = 1'b0;
    case (state_q)
      CFG_IDLE: begin
        if (cfg_valid) begin
          if (req_ok) begin
            load_shadow = 1'b1;
            state_d     = CFG_PENDING;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      CFG_PENDING: begin
        if (enable && h_wrap && v_wrap) begin
          apply   = 1'b1;
          state_d = CFG_IDLE;
        end
      end
      default: state_d = CFG_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= CFG_IDLE;
      cfg_err <= 1'b0;
      act     <= DEF_CFG;
      shadow  <= DEF_CFG;
    end else begin
      state_q <= state_d;
      cfg_err <= err_d;
      if (load_shadow) shadow <= cfg_req;
      if (apply)       act    <= shadow;
    end
  end

  assign cfg_ready = (state_q == CFG_IDLE);

  vga_axis_counter #(.W(HW)) u_h (
    .clk         (clk),
    .reset       (reset),
    .advance     (enable),
    .max         (act_hd.max[HW+1:0]),
    .sync_start  (eff_hd.sync_start[HW+1:0]),
    .sync_end    (eff_hd.sync_end[HW+1:0]),
    .display     (eff.h_display),
    .pos         (hpos),
    .wrap        (h_wrap),
    .next_pos    (h_next),
    .sync_next   (h_sync_next),
    .active_next (h_active_next)
  );

  vga_axis_counter #(.W(VW)) u_v (
    .clk         (clk),
    .reset       (reset),
    .advance     (enable && h_wrap),
    .max         (act_vd.max[VW+1:0]),
    .sync_start  (eff_vd.sync_start[VW+1:0]),
    .sync_end    (eff_vd.sync_end[VW+1:0]),
    .display     (eff.v_display),
    .pos         (vpos),
    .wrap        (v_wrap),
    .next_pos    (v_next),
    .sync_next   (v_sync_next),
    .active_next (v_active_next)
  );

  // Polarity is folded in at the first stage so in-flight samples keep theirs.
  assign stage_d = {h_sync_next ~^ eff.hsync_pol,
                    v_sync_next ~^ eff.vsync_pol,
                    h_active_next && v_active_next,
                    (h_next == '0) && (v_next == '0),
                    (h_next == '0)};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i <= SYNC_DELAY; i++) pipe[i] <= PIPE_RST;
    end else if (enable) begin
      pipe[0] <= stage_d;
      for (int i = 1; i <= SYNC_DELAY; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign {hsync, vsync, display_on, frame_start, line_start} = pipe[SYNC_DELAY];

endmodule

// File: tb/tb_vga_timing_prog.sv
// Self-checking bench: a pixel-level reference model predicts every output each cycle;
// literal period/edge checks pin the model. Reset mode is shrunk to keep runs short.
module tb_vga_timing_prog;

  localparam int HW = 11;
  localparam int VW = 10;
  localparam int D  = 2;
  localparam int DEFS[8] = '{20, 4, 6, 2, 12, 2, 2, 3};

  logic clk, reset, enable, cfg_valid, cfg_ready, cfg_err;
  logic [HW-1:0] cfg_h_display, cfg_h_front, cfg_h_sync, cfg_h_back;
  logic [VW-1:0] cfg_v_display, cfg_v_bottom, cfg_v_sync, cfg_v_top;
  logic cfg_hsync_pol, cfg_vsync_pol;
  logic hsync, vsync, display_on, frame_start, line_start;
  logic [HW-1:0] hpos;
  logic [VW-1:0] vpos;

  vga_timing_prog #(
    .HPOS_WIDTH(HW), .VPOS_WIDTH(VW), .SYNC_DELAY(D),
    .DEF_H_DISPLAY(20), .DEF_H_FRONT(4), .DEF_H_SYNC(6), .DEF_H_BACK(2),
    .DEF_V_DISPLAY(12), .DEF_V_BOTTOM(2), .DEF_V_SYNC(2), .DEF_V_TOP(3),
    .DEF_HSYNC_POL(1'b0), .DEF_VSYNC_POL(1'b0)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_h_display(cfg_h_display), .cfg_h_front(cfg_h_front),
    .cfg_h_sync(cfg_h_sync), .cfg_h_back(cfg_h_back),
    .cfg_v_display(cfg_v_display), .cfg_v_bottom(cfg_v_bottom),
    .cfg_v_sync(cfg_v_sync), .cfg_v_top(cfg_v_top),
    .cfg_hsync_pol(cfg_hsync_pol), .cfg_vsync_pol(cfg_vsync_pol),
    .cfg_err(cfg_err), .hsync(hsync), .vsync(vsync), .display_on(display_on),
    .frame_start(frame_start), .line_start(line_start), .hpos(hpos), .vpos(vpos)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: dut=%0d expected=%0d", name, got, exp);
    end
  endtask

  // Reference model: active/shadow config as plain integers, pixel position,
  // and a history of ideal output levels indexed by enable steps of age.
  int ma[8], ms[8];
  bit ma_hp, ma_vp, ms_hp, ms_vp, m_pend, m_err;
  int mh, mv;
  logic [4:0] hist [0:D];

  function automatic int last_of(input int a, input int b, input int c, input int d);
    return a + b + c + d - 1;
  endfunction

  function automatic logic [4:0] levels(input int x, input int y);
    bit hs, vs, de;
    hs = (x >= ma[0] + ma[1]) && (x < ma[0] + ma[1] + ma[2]);
    vs = (y >= ma[4] + ma[5]) && (y < ma[4] + ma[5] + ma[6]);
    de = (x < ma[0]) && (y < ma[4]);
    return {hs ? ma_hp : !ma_hp, vs ? ma_vp : !ma_vp, de, (x == 0 && y == 0), (x == 0)};
  endfunction

  task automatic model_reset();
    ma = DEFS; ms = DEFS;
    ma_hp = 0; ma_vp = 0; ms_hp = 0; ms_vp = 0;
    m_pend = 0; m_err = 0; mh = 0; mv = 0;
    for (int k = 0; k <= D; k++) hist[k] = 5'b11000;
  endtask

  always @(posedge clk) begin : model
    bit p0, apply, ok;
    int hm, vm;
    int rq[8];
    if (reset) begin
      model_reset();
    end else begin
      p0 = m_pend;
      hm = last_of(ma[0], ma[1], ma[2], ma[3]);
      vm = last_of(ma[4], ma[5], ma[6], ma[7]);
      apply = enable && p0 && (mh == hm) && (mv == vm);
      m_err = 0;
      if (cfg_valid && !p0) begin
        rq = '{int'(cfg_h_display), int'(cfg_h_front), int'(cfg_h_sync), int'(cfg_h_back),
               int'(cfg_v_display), int'(cfg_v_bottom), int'(cfg_v_sync), int'(cfg_v_top)};
        ok = 1;
        for (int k = 0; k < 8; k++) if (rq[k] == 0) ok = 0;
        if (last_of(rq[0], rq[1], rq[2], rq[3]) >= (1 << HW)) ok = 0;
        if (last_of(rq[4], rq[5], rq[6], rq[7]) >= (1 << VW)) ok = 0;
        if (ok) begin
          ms = rq; ms_hp = cfg_hsync_pol; ms_vp = cfg_vsync_pol; m_pend = 1;
        end else begin
          m_err = 1;
        end
      end
      if (enable) begin
        if (apply) begin
          ma = ms; ma_hp = ms_hp; ma_vp = ms_vp; m_pend = 0;
        end
        if (mh == hm) begin
          mh = 0;
          mv = (mv == vm) ? 0 : mv + 1;
        end else begin
          mh = mh + 1;
        end
        for (int k = D; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = levels(mh, mv);
      end
    end
  end

  // Edge/period monitor, fed from the same sample point as the per-cycle compare.
  int cyc = 0, fs_cnt = 0, fs_t = 0, fs_period = -1, ls_t = 0, ls_period = -1;
  int fs_hpos = -1, de_acc = 0, de_per_frame = -1, de_rise_hpos = -1;
  int hs_rise_hpos = -1, hs_fall_hpos = -1, vs_rise_vpos = -1, vs_fall_vpos = -1;
  logic fs_q, ls_q, de_q, hs_q, vs_q;

  always @(posedge clk) begin
    #1;
    if (reset) begin
      fs_q = 0; ls_q = 0; de_q = 0; hs_q = hsync; vs_q = vsync;
      de_acc = 0; fs_period = -1; ls_period = -1; fs_hpos = -1; de_per_frame = -1;
      de_rise_hpos = -1; hs_rise_hpos = -1; hs_fall_hpos = -1; vs_rise_vpos = -1; vs_fall_vpos = -1;
    end else begin
      check("hpos", int'(hpos), mh);
      check("vpos", int'(vpos), mv);
      check("hsync", int'(hsync), int'(hist[D][4]));
      check("vsync", int'(vsync), int'(hist[D][3]));
      check("display_on", int'(display_on), int'(hist[D][2]));
      check("frame_start", int'(frame_start), int'(hist[D][1]));
      check("line_start", int'(line_start), int'(hist[D][0]));
      check("cfg_ready", int'(cfg_ready), int'(!m_pend));
      check("cfg_err", int'(cfg_err), int'(m_err));
      cyc++;
      if (frame_start && !fs_q) begin
        fs_period = cyc - fs_t; fs_t = cyc; fs_cnt++; fs_hpos = int'(hpos);
        de_per_frame = de_acc; de_acc = 0;
      end
      if (display_on) de_acc++;
      if (line_start && !ls_q) begin ls_period = cyc - ls_t; ls_t = cyc; end
      if (hsync && !hs_q) hs_rise_hpos = int'(hpos);
      if (!hsync && hs_q) hs_fall_hpos = int'(hpos);
      if (vsync && !vs_q) vs_rise_vpos = int'(vpos);
      if (!vsync && vs_q) vs_fall_vpos = int'(vpos);
      if (display_on && !de_q) de_rise_hpos = int'(hpos);
      fs_q = frame_start; ls_q = line_start; de_q = display_on; hs_q = hsync; vs_q = vsync;
    end
  end

  task automatic cyc_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_cfg(input int hd, input int hf, input int hs, input int hb,
                          input int vd, input int vb, input int vs, input int vt,
                          input bit hp, input bit vp);
    cfg_h_display = HW'(hd); cfg_h_front = HW'(hf); cfg_h_sync = HW'(hs); cfg_h_back = HW'(hb);
    cfg_v_display = VW'(vd); cfg_v_bottom = VW'(vb); cfg_v_sync = VW'(vs); cfg_v_top = VW'(vt);
    cfg_hsync_pol = hp; cfg_vsync_pol = vp;
    cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic wait_ready(input int budget);
    int k = 0;
    while (!cfg_ready && k < budget) begin @(negedge clk); k++; end
    check("ready_wait", int'(cfg_ready), 1);
  endtask

  task automatic wait_fs(input int budget);
    int k = 0;
    while (!frame_start && k < budget) begin @(negedge clk); k++; end
    check("fs_wait", int'(frame_start), 1);
  endtask

  task automatic measure(input int n, input string tag, input int fp, input int lp);
    int n0 = fs_cnt;
    cyc_n(n);
    check({tag, "_frames_seen"}, int'(fs_cnt - n0 >= 2), 1);
    check({tag, "_frame_period"}, fs_period, fp);
    check({tag, "_line_period"}, ls_period, lp);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_hpos"}, int'(hpos), 0);
    check({tag, "_vpos"}, int'(vpos), 0);
    check({tag, "_hsync"}, int'(hsync), 1);
    check({tag, "_vsync"}, int'(vsync), 1);
    check({tag, "_display_on"}, int'(display_on), 0);
    check({tag, "_frame_start"}, int'(frame_start), 0);
    check({tag, "_line_start"}, int'(line_start), 0);
    check({tag, "_cfg_ready"}, int'(cfg_ready), 1);
    check({tag, "_cfg_err"}, int'(cfg_err), 0);
  endtask

  initial begin
    reset = 1; enable = 0; cfg_valid = 0;
    cfg_h_display = '0; cfg_h_front = '0; cfg_h_sync = '0; cfg_h_back = '0;
    cfg_v_display = '0; cfg_v_bottom = '0; cfg_v_sync = '0; cfg_v_top = '0;
    cfg_hsync_pol = 0; cfg_vsync_pol = 0;
    repeat (3) @(negedge clk);
    check_reset_state("rst");
    reset = 0; enable = 1;

    // Reset mode: 32 clocks/line, 19 lines, hsync low from column 24, outputs lag 2.
    measure(3 * 608 + 50, "def", 608, 32);
    check("def_hs_fall_hpos", hs_fall_hpos, 26);
    check("def_vs_fall_vpos", vs_fall_vpos, 14);
    check("def_fs_hpos", fs_hpos, 2);
    check("def_de_rise_hpos", de_rise_hpos, 2);
    check("def_de_per_frame", de_per_frame, 240);

    // Small mode accepted mid-frame, swapped in at the wrap.
    cyc_n(100);
    send_cfg(8, 2, 3, 1, 4, 1, 2, 1, 1, 1);
    check("small_ready_low", int'(cfg_ready), 0);
    wait_ready(700);
    measure(3 * 112 + 20, "small", 112, 14);
    check("small_hs_rise_hpos", hs_rise_hpos, 12);
    check("small_vs_rise_vpos", vs_rise_vpos, 5);
    check("small_fs_hpos", fs_hpos, 2);
    check("small_de_per_frame", de_per_frame, 32);

    // One enable in three: everything stretches by exactly 3.
    begin
      int n0 = fs_cnt;
      for (int i = 0; i < 3 * 336 + 40; i++) begin
        enable = (i % 3 == 0);
        @(negedge clk);
      end
      check("slow_frames_seen", int'(fs_cnt - n0 >= 2), 1);
      check("slow_frame_period", fs_period, 336);
      check("slow_line_period", ls_period, 42);
      check("slow_hs_rise_hpos", hs_rise_hpos, 12);
    end
    enable = 1;
    cyc_n(120);

    // Rejected configs: zero field, H overflow, V overflow.
    send_cfg(8, 2, 0, 1, 4, 1, 2, 1, 1, 1);
    check("zero_err", int'(cfg_err), 1);
    check("zero_ready", int'(cfg_ready), 1);
    @(negedge clk);
    check("zero_err_clear", int'(cfg_err), 0);
    send_cfg(2000, 40, 10, 10, 4, 1, 2, 1, 1, 1);
    check("hovf_err", int'(cfg_err), 1);
    check("hovf_ready", int'(cfg_ready), 1);
    @(negedge clk);
    check("hovf_err_clear", int'(cfg_err), 0);
    send_cfg(8, 2, 3, 1, 1000, 20, 4, 4, 0, 0);
    check("vovf_err", int'(cfg_err), 1);
    measure(3 * 112 + 20, "after_err", 112, 14);

    // Reset mid-line while a config is pending.
    wait_fs(200);
    send_cfg(6, 1, 1, 1, 3, 1, 1, 1, 0, 0);
    cyc_n(3);
    check("pend_ready_low", int'(cfg_ready), 0);
    reset = 1;
    @(negedge clk);
    check_reset_state("midrst");
    reset = 0;
    measure(3 * 608 + 50, "resume", 608, 32);
    check("resume_hs_fall_hpos", hs_fall_hpos, 26);

    // Random enable and random (valid and invalid) config requests.
    for (int i = 0; i < 3000; i++) begin
      enable = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 39) == 0) begin
        cfg_h_display = HW'($urandom_range(1, 6)); cfg_h_front = HW'($urandom_range(1, 6));
        cfg_h_sync    = HW'($urandom_range(1, 6)); cfg_h_back  = HW'($urandom_range(1, 6));
        cfg_v_display = VW'($urandom_range(1, 4)); cfg_v_bottom = VW'($urandom_range(1, 4));
        cfg_v_sync    = VW'($urandom_range(1, 4)); cfg_v_top    = VW'($urandom_range(1, 4));
        case ($urandom_range(0, 7))
          0: cfg_h_sync = '0;
          1: cfg_v_top = '0;
          2: cfg_h_display = HW'(2047);
          default: ;
        endcase
        cfg_hsync_pol = 1'($urandom_range(0, 1));
        cfg_vsync_pol = 1'($urandom_range(0, 1));
        cfg_valid = 1;
      end else begin
        cfg_valid = 0;
      end
      @(negedge clk);
    end
    cfg_valid = 0;
    enable = 1;
    cyc_n(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
